// File: rtl/spram_fifo_sched.sv
// -----------------------------------------------------------------------------
// spram_fifo_sched
//
// Front-end scheduler for a single-port-RAM FIFO that can execute at most one
// write or one read per cycle. A producer push stream is turned into FIFO write
// commands. The scheduler prefetches FIFO words into a 2-entry output buffer
// that feeds a consumer stream. Pushes and prefetch reads compete for the one
// FIFO port. When both are eligible in the same cycle, they take turns.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   push_valid      producer has a word
//   push_data       producer word
//   push_ready      push granted this cycle (combinational, 0 while in reset)
//   out_valid       output buffer head is valid
//   out_data        output buffer head
//   out_ready       consumer takes the head this cycle
//   inst            registered FIFO command {WE, RE, DI}
//   fifo_do         FIFO read data
//   fifo_read_valid FIFO read data valid
//   count           words held in FIFO storage, net of reads already issued
//   full            count == DEPTH
//   empty           count == 0
//   err             sticky: read data returned with no read outstanding
// -----------------------------------------------------------------------------
module spram_fifo_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [DATA_WIDTH+1:0] inst,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  input  logic                  fifo_read_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] Depth = CntW'(1) << ADDR_WIDTH;

  // A read issued every cycle overlaps with at most READ_LAT older reads. The
  // 2-slot output buffer also caps outstanding reads at 2, so the counter only
  // needs to hold min(READ_LAT+1, 2).
  localparam int unsigned MaxInflight = (READ_LAT + 1 < 2) ? READ_LAT + 1 : 2;
  localparam int unsigned InflW       = $clog2(MaxInflight + 1);

  // Last port owner. Reset value is GrantRead, so the first tie goes to a write.
  localparam logic GrantRead  = 1'b0;
  localparam logic GrantWrite = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH+1:0] inst_q, inst_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [InflW-1:0]      inflight_q, inflight_d;
  logic                  last_grant_q, last_grant_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] buf_mem_q [2];
  logic                  buf_head_q, buf_head_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration
  // ---------------------------------------------------------------------------
  logic wr_elig, rd_elig;
  logic grant_wr, grant_rd;

  always_comb begin
    wr_elig  = push_valid && (count_q < Depth);
    // Outstanding reads already hold a buffer slot, so the total stays <= 2.
    rd_elig  = (count_q != '0) && ((3'(buf_cnt_q) + 3'(inflight_q)) < 3'd2);
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (wr_elig && rd_elig) begin
      if (last_grant_q == GrantRead) begin
        grant_wr = 1'b1;
      end else begin
        grant_rd = 1'b1;
      end
    end else begin
      grant_wr = wr_elig;
      grant_rd = rd_elig;
    end
  end

  assign push_ready = grant_wr & rst;

  // ---------------------------------------------------------------------------
  // Read return and output buffer control
  // ---------------------------------------------------------------------------
  logic fill, stray, pop;
  logic buf_wr_idx;

  assign fill       = fifo_read_valid && (inflight_q != '0);
  assign stray      = fifo_read_valid && (inflight_q == '0);
  assign pop        = out_valid && out_ready;
  // The slot after the last valid entry. A fill never sees buf_cnt == 2.
  assign buf_wr_idx = buf_head_q ^ buf_cnt_q[0];

  always_comb begin
    buf_cnt_d = buf_cnt_q;
    if (fill && !pop) begin
      buf_cnt_d = buf_cnt_q + 2'd1;
    end else if (!fill && pop) begin
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    buf_head_d = pop ? ~buf_head_q : buf_head_q;
  end

  // ---------------------------------------------------------------------------
  // Command, occupancy and status next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_d = '0;
    if (grant_wr) begin
      inst_d = {2'b10, push_data};
    end else if (grant_rd) begin
      inst_d = {2'b01, {DATA_WIDTH{1'b0}}};
    end

    // A read is subtracted when it is granted, not when its data returns.
    count_d = count_q;
    if (grant_wr) begin
      count_d = count_q + CntW'(1);
    end else if (grant_rd) begin
      count_d = count_q - CntW'(1);
    end

    inflight_d = inflight_q;
    if (grant_rd && !fill) begin
      inflight_d = inflight_q + InflW'(1);
    end else if (!grant_rd && fill) begin
      inflight_d = inflight_q - InflW'(1);
    end

    last_grant_d = last_grant_q;
    if (grant_wr) begin
      last_grant_d = GrantWrite;
    end else if (grant_rd) begin
      last_grant_d = GrantRead;
    end

    err_d = err_q | stray;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q       <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      last_grant_q <= GrantRead;
      err_q        <= 1'b0;
      buf_head_q   <= 1'b0;
      buf_cnt_q    <= 2'd0;
    end else begin
      inst_q       <= inst_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      buf_head_q   <= buf_head_d;
      buf_cnt_q    <= buf_cnt_d;
    end
  end

  // Buffer storage is reset so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_mem_q[0] <= '0;
      buf_mem_q[1] <= '0;
    end else if (fill) begin
      buf_mem_q[buf_wr_idx] <= fifo_do;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inst      = inst_q;
  assign count     = count_q;
  assign full      = (count_q == Depth);
  assign empty     = (count_q == '0);
  assign err       = err_q;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf_mem_q[buf_head_q];

endmodule

// File: tb/tb_spram_fifo_sched.sv
module tb_spram_fifo_sched;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [DW+1:0] inst;
  logic [DW-1:0] fifo_do;
  logic          fifo_read_valid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          err;

  spram_fifo_sched #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_LAT  (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_data      (push_data),
    .push_ready     (push_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .inst           (inst),
    .fifo_do        (fifo_do),
    .fifo_read_valid(fifo_read_valid),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // SPRAM FIFO environment: stores DI on WE, returns the oldest word one cycle
  // after an RE cycle.
  logic [DW-1:0] mem_q[$];
  bit            pend;
  logic [DW-1:0] pend_data;

  // Reference model: words stored (not yet read), reads issued but not
  // returned, output buffer contents, last grant, sticky error, expected inst.
  logic [DW-1:0] m_store[$];
  logic [DW-1:0] m_pending[$];
  logic [DW-1:0] m_buf[$];
  bit            m_last_wr;
  bit            m_err;
  logic [DW+1:0] m_inst;

  // Observations of the DUT used by the phase-level checks.
  int            n_acc;
  int            n_re;
  logic [DW+1:0] last_inst;
  logic [DW-1:0] popped[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_store.delete();
    m_pending.delete();
    m_buf.delete();
    m_last_wr = 1'b0;
    m_err     = 1'b0;
    m_inst    = '0;
    mem_q.delete();
    pend      = 1'b0;
    pend_data = '0;
  endtask

  // Called away from the rising edge: asserts reset, checks its immediate
  // effect, then releases it on the next falling edge.
  task automatic apply_reset();
    rst             = 1'b0;
    push_valid      = 1'b1;
    push_data       = 8'h5A;
    out_ready       = 1'b0;
    fifo_read_valid = 1'b0;
    fifo_do         = '0;
    #1;
    check("rst_push_ready", push_ready, 1'b0);
    check("rst_inst", inst, '0);
    check("rst_count", count, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_err", err, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    model_reset();
    @(negedge clk);
    push_valid = 1'b0;
    rst        = 1'b1;
  endtask

  // One clock cycle: drive inputs, check all outputs against the model, then
  // advance the model and the FIFO environment to the next edge.
  task automatic step(input bit pv, input logic [DW-1:0] pd, input bit ordy,
                      input bit force_rv, output bit took);
    bit wr_e, rd_e, gw, gr, rv;
    @(negedge clk);
    push_valid = pv;
    push_data  = pd;
    out_ready  = ordy;
    rv         = force_rv ? 1'b1 : pend;
    fifo_read_valid = rv;
    fifo_do    = force_rv ? 8'hAA : (pend ? pend_data : 8'h00);
    #1;
    wr_e = pv && (m_store.size() < DEPTH);
    rd_e = (m_store.size() > 0) && ((m_buf.size() + m_pending.size()) < 2);
    gw   = wr_e && (!rd_e || !m_last_wr);
    gr   = rd_e && (!wr_e || m_last_wr);
    check("push_ready", push_ready, gw);
    check("inst", inst, m_inst);
    check("count", count, m_store.size());
    check("full", full, m_store.size() == DEPTH);
    check("empty", empty, m_store.size() == 0);
    check("out_valid", out_valid, m_buf.size() != 0);
    check("err", err, m_err);
    if (m_buf.size() != 0) check("out_data", out_data, m_buf[0]);

    if (push_valid && push_ready) n_acc++;
    if (inst[DW]) n_re++;
    if (out_valid && out_ready) popped.push_back(out_data);
    last_inst = inst;

    pend = 1'b0;
    if (inst[DW+1]) mem_q.push_back(inst[DW-1:0]);
    if (inst[DW]) begin
      pend      = 1'b1;
      pend_data = (mem_q.size() != 0) ? mem_q.pop_front() : '0;
    end

    if ((m_buf.size() != 0) && ordy) void'(m_buf.pop_front());
    if (rv) begin
      if (m_pending.size() != 0) m_buf.push_back(m_pending.pop_front());
      else m_err = 1'b1;
    end
    if (gw) begin
      m_store.push_back(pd);
      m_inst    = {2'b10, pd};
      m_last_wr = 1'b1;
    end else if (gr) begin
      m_pending.push_back(m_store.pop_front());
      m_inst    = {2'b01, 8'h00};
      m_last_wr = 1'b0;
    end else begin
      m_inst = '0;
    end
    took = gw;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] words1 [3];
    logic [DW-1:0] words2 [12];
    logic [11:0]   pat;
    bit            took;
    int            idx;
    int            guard;

    rst             = 1'b0;
    push_valid      = 1'b0;
    push_data       = '0;
    out_ready       = 1'b0;
    fifo_read_valid = 1'b0;
    fifo_do         = '0;
    model_reset();
    last_inst = '0;

    // Reset, then three pushes with the consumer stalled.
    @(negedge clk);
    apply_reset();
    words1[0] = 8'h11;
    words1[1] = 8'h22;
    words1[2] = 8'h33;
    n_acc = 0;
    idx   = 0;
    guard = 0;
    while (idx < 3 && guard < 12) begin
      step(1'b1, words1[idx], 1'b0, 1'b0, took);
      if (took) idx++;
      guard++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, took);
    check("t1_accepted", n_acc, 3);

    // Stalled consumer, 12 words offered: FIFO fills, exactly two prefetches.
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 12; i++) words2[i] = 8'($urandom);
    n_acc = 0;
    n_re  = 0;
    idx   = 0;
    for (int c = 0; c < 24; c++) begin
      step(idx < 12, (idx < 12) ? words2[idx] : 8'h00, 1'b0, 1'b0, took);
      if (took) idx++;
    end
    check("t2_full", full, 1'b1);
    check("t2_count", count, DEPTH);
    check("t2_push_ready", push_ready, 1'b0);
    check("t2_reads", n_re, 2);
    check("t2_accepted", n_acc, 10);
    check("t2_head", out_data, words2[0]);

    // Drain: words leave in push order with no gaps or repeats.
    popped.delete();
    for (int c = 0; c < 40; c++) step(1'b0, 8'h00, 1'b1, 1'b0, took);
    check("t3_pops", popped.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < popped.size()) check("t3_order", popped[i], words2[i]);
    end
    check("t3_empty", empty, 1'b1);

    // Alternating grants out of reset.
    @(negedge clk);
    apply_reset();
    pat = '0;
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0, took);
      if (c > 0) pat = {pat[9:0], last_inst[DW+1:DW]};
    end
    check("t4_grant_pattern", pat, 12'h999);

    // Stray read data: dropped, err set and held, buffer untouched.
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 1'b1, 1'b0, took);
    step(1'b1, 8'h5C, 1'b0, 1'b0, took);
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b0, 1'b0, took);
    step(1'b0, 8'h00, 1'b0, 1'b1, took);
    for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 1'b0, 1'b0, took);
    check("t5_err", err, 1'b1);
    check("t5_out_valid", out_valid, 1'b1);
    check("t5_out_data", out_data, 8'h5C);

    // Reset with a read in flight and four words stored.
    @(negedge clk);
    apply_reset();
    guard = 0;
    while (m_store.size() < 5 && guard < 30) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0, took);
      guard++;
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, took);
    guard = 0;
    while (m_pending.size() == 0 && guard < 4) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, took);
      guard++;
    end
    @(negedge clk);
    #1;
    check("t6_pre_count", count, 4);
    apply_reset();
    for (int c = 0; c < 12; c++) step(c < 6, 8'($urandom), 1'b1, 1'b0, took);
    check("t6_err", err, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 50, 1'b0, took);
    end
    for (int c = 0; c < 40; c++) step(1'b0, 8'h00, 1'b1, 1'b0, took);
    check("final_empty", empty, 1'b1);
    check("final_out_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
